radix_counter_cascade: RTL and testbench

//  Parametrised multi-digit counter: DIGITS cascaded digit stages, each counting 0..RADIX-1,

---
 rtl/radix_counter_cascade.sv | 111 +++++++++++
 tb/tb_radix_counter_cascade.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/radix_counter_cascade.sv
// Multi-digit cascaded radix counter (up/down, load, clear) with same-cycle carry chain; o_count 1-cycle latency, no backpressure.
// RADIX_CNT_SAT_EN: when defined, an enabled step at terminal value holds (saturates) instead of wrapping.
module radix_counter_cascade #(
  parameter int RADIX  = 8,
  parameter int DIGITS = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_enable,
  input  logic                                  i_up,
  input  logic                                  i_clear,
  input  logic                                  i_load,
  input  logic [DIGITS*$clog2(RADIX)-1:0]       i_load_val,
  output logic [DIGITS*$clog2(RADIX)-1:0]       o_count,
  output logic                                  o_tc,
  output logic                                  o_wrap,
  output logic                                  o_load_err
);

  localparam int DIGIT_W = $clog2(RADIX);
  localparam int CW      = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] D_MAX = DIGIT_W'(RADIX - 1);
  localparam logic [DIGIT_W:0]   D_MOD = (DIGIT_W + 1)'(RADIX);

  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [DIGITS-1:0] at_max, at_zero, step;
  logic [CW-1:0]     stepped;
  logic [CW-1:0]     load_clamped;
  logic              load_oor;
  logic              terminal;

  // Carry/borrow chain: digit k steps when every lower digit sits at its roll-over value.
  always_comb begin
    at_max  = '0;
    at_zero = '0;
    step    = '0;
    stepped = count_q;
    for (int k = 0; k < DIGITS; k++) begin
      at_max[k]  = (count_q[k*DIGIT_W +: DIGIT_W] == D_MAX);
      at_zero[k] = (count_q[k*DIGIT_W +: DIGIT_W] == '0);
    end
    step[0] = i_enable;
    for (int k = 1; k < DIGITS; k++) begin
      step[k] = step[k-1] & (i_up ? at_max[k-1] : at_zero[k-1]);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (step[k]) begin
        if (i_up) begin
          stepped[k*DIGIT_W +: DIGIT_W] = at_max[k] ? '0
                                        : count_q[k*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
        end else begin
          stepped[k*DIGIT_W +: DIGIT_W] = at_zero[k] ? D_MAX
                                        : count_q[k*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
        end
      end
    end
  end

  assign terminal = i_up ? (&at_max) : (&at_zero);
  assign o_tc     = i_enable & terminal;

  // Out-of-range load digits clamp to the largest legal digit and flag an error.
  always_comb begin
    load_clamped = i_load_val;
    load_oor     = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ({1'b0, i_load_val[k*DIGIT_W +: DIGIT_W]} >= D_MOD) begin
        load_clamped[k*DIGIT_W +: DIGIT_W] = D_MAX;
        load_oor = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = load_clamped;
      err_d   = load_oor;
    end else if (i_enable) begin
`ifdef RADIX_CNT_SAT_EN
      count_d = terminal ? count_q : stepped;
`else
      count_d = stepped;
`endif
      wrap_d  = terminal;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign o_count    = count_q;
  assign o_wrap     = wrap_q;
  assign o_load_err = err_q;

endmodule

// File: tb/tb_radix_counter_cascade.sv
// Scoreboard bench: two counter instances (radix 8 x2 digits, radix 10 x3 digits) against an integer reference model.
module tb_radix_counter_cascade;

  logic        clk;
  logic        rst_n, enable, up, clear, load;
  logic [5:0]  lva;
  logic [11:0] lvb;
  logic [5:0]  cnt_a;
  logic [11:0] cnt_b;
  logic        tc_a, wrap_a, err_a, tc_b, wrap_b, err_b;

  radix_counter_cascade #(.RADIX(8), .DIGITS(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_up(up), .i_clear(clear),
    .i_load(load), .i_load_val(lva), .o_count(cnt_a), .o_tc(tc_a),
    .o_wrap(wrap_a), .o_load_err(err_a));

  radix_counter_cascade #(.RADIX(10), .DIGITS(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_up(up), .i_clear(clear),
    .i_load(load), .i_load_val(lvb), .o_count(cnt_b), .o_tc(tc_b),
    .o_wrap(wrap_b), .o_load_err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          tc_chk;
    logic        tca, tcb;
    logic [5:0]  ca;
    logic [11:0] cb;
    logic        wa, ea, wb, eb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   va = 0, vb = 0;
  bit   known = 0;
  bit   done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Value held as a plain integer modulo RADIX^DIGITS; digits only appear when packing.
  task automatic model(input int radix, input int digits, input int w, input logic [31:0] lv,
                       input bit r_n, input bit en, input bit u, input bit clr, input bit ld,
                       inout int val, output bit tc, output bit wrap, output bit err);
    int m, d;
    m = 1;
    for (int k = 0; k < digits; k++) m = m * radix;
    tc   = en && (u ? (val == m - 1) : (val == 0));
    wrap = 0;
    err  = 0;
    if (!r_n || clr) val = 0;
    else if (ld) begin
      val = 0;
      for (int k = digits - 1; k >= 0; k--) begin
        d = int'((lv >> (k * w)) & ((32'd1 << w) - 1));
        if (d >= radix) begin d = radix - 1; err = 1; end
        val = val * radix + d;
      end
    end else if (en) begin
      if (tc) begin
        wrap = 1;
`ifndef RADIX_CNT_SAT_EN
        val = u ? 0 : m - 1;
`endif
      end else begin
        val = u ? val + 1 : val - 1;
      end
    end
  endtask

  function automatic logic [31:0] pack(input int val, input int radix, input int digits, input int w);
    logic [31:0] r;
    int v;
    r = '0;
    v = val;
    for (int k = 0; k < digits; k++) begin
      r = r | (32'(v % radix) << (k * w));
      v = v / radix;
    end
    return r;
  endfunction

  task automatic drive(input bit r_n, input bit en, input bit u, input bit clr, input bit ld,
                       input logic [5:0] la, input logic [11:0] lb);
    exp_t e;
    bit t, wr, er;
    logic [31:0] p;
    @(posedge clk);
    #1;
    rst_n = r_n; enable = en; up = u; clear = clr; load = ld; lva = la; lvb = lb;
    e.tc_chk = known;
    model(8, 2, 3, 32'(la), r_n, en, u, clr, ld, va, t, wr, er);
    e.tca = t; e.wa = wr; e.ea = er;
    if (!r_n) begin e.wa = 0; e.ea = 0; end
    p = pack(va, 8, 2, 3);
    e.ca = p[5:0];
    model(10, 3, 4, 32'(lb), r_n, en, u, clr, ld, vb, t, wr, er);
    e.tcb = t; e.wb = wr; e.eb = er;
    if (!r_n) begin e.wb = 0; e.eb = 0; end
    p = pack(vb, 10, 3, 4);
    e.cb = p[11:0];
    if (!r_n) known = 1;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 0; enable = 0; up = 1; clear = 0; load = 0; lva = '0; lvb = '0;
    fork
      begin : driver
        bit u;
        logic [5:0]  ra;
        logic [11:0] rb;
        repeat (3) drive(0, 0, 1, 0, 0, 6'o00, 12'h000);
        repeat (64) drive(1, 1, 1, 0, 0, 6'o00, 12'h000);        // full cycle 00..77..00
        drive(1, 0, 1, 0, 1, 6'o05, 12'h005);                    // load 05
        repeat (6) drive(1, 1, 0, 0, 0, 6'o00, 12'h000);         // count down through 00 to 77
        drive(1, 0, 1, 1, 0, 6'o00, 12'h000);
        repeat (29) drive(1, 1, 1, 0, 0, 6'o00, 12'h000);        // reach 35
        drive(0, 1, 1, 0, 0, 6'o00, 12'h000);                    // reset mid-count
        drive(1, 0, 1, 0, 0, 6'o00, 12'h000);
        drive(1, 1, 1, 1, 1, 6'o42, 12'h042);                    // clear beats load and enable
        drive(1, 0, 1, 0, 1, 6'o42, 12'h042);
        drive(1, 0, 1, 0, 1, 6'o42, 12'h9C3);                    // radix-10 digit 12 clamps to 9
        repeat (2) drive(1, 0, 1, 0, 0, 6'o00, 12'h000);
        drive(1, 1, 1, 0, 1, 6'o76, 12'h998);                    // load ignores enable
        repeat (3) drive(1, 1, 1, 0, 0, 6'o00, 12'h000);
        repeat (2) drive(1, 0, 1, 0, 0, 6'o00, 12'h000);
        drive(1, 0, 0, 0, 1, 6'o01, 12'h001);
        repeat (3) drive(1, 1, 0, 0, 0, 6'o00, 12'h000);         // down through zero, both widths
        u = 1;
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 31) == 0) u = ~u;
          ra = 6'($urandom);
          case ($urandom_range(0, 3))
            0: rb = 12'h999;
            1: rb = 12'h000;
            default: rb = 12'($urandom);
          endcase
          drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, u,
                $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, ra, rb);
        end
        drive(1, 0, 1, 0, 0, 6'o00, 12'h000);
        done = 1;
      end
      begin : monitor
        exp_t e;
        int idle;
        idle = 0;
        forever begin
          @(negedge clk);
          if (q.size() == 0) begin
            if (done) break;
            idle++;
            if (idle > 50) begin
              fails++;
              $display("FAIL monitor_timeout: no expected item for %0d cycles", idle);
              break;
            end
          end else begin
            idle = 0;
            e = q.pop_front();
            if (e.tc_chk) begin
              chk("tc_a", 32'(tc_a), 32'(e.tca));
              chk("tc_b", 32'(tc_b), 32'(e.tcb));
            end
            @(posedge clk);
            #2;
            chk("count_a", 32'(cnt_a), 32'(e.ca));
            chk("wrap_a", 32'(wrap_a), 32'(e.wa));
            chk("load_err_a", 32'(err_a), 32'(e.ea));
            chk("count_b", 32'(cnt_b), 32'(e.cb));
            chk("wrap_b", 32'(wrap_b), 32'(e.wb));
            chk("load_err_b", 32'(err_b), 32'(e.eb));
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
